serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Function : Bit-serial add controller driving an external 1-bit full adder,
//            LSB first. Optional subtract mode under `SERIAL_ADD_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = w_run && (r_cnt == c_LAST);

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force a carry-in of one.
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : cin;
`else
    assign w_b_load   = b;
    assign w_cin_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= w_b_load;
                r_carry <= w_cin_load;
                r_cnt   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
            end else if (w_run) begin
                // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                r_sum   <= {fa_sum, r_sum[WIDTH-1:1]};
                r_carry <= fa_cout;
                r_a_sh  <= r_a_sh >> 1;
                r_b_sh  <= r_b_sh >> 1;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cout <= fa_cout;
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;
    assign fa_a   = w_run & r_a_sh[0];
    assign fa_b   = w_run & r_b_sh[0];
    assign fa_cin = w_run & r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Function : Directed self-checking bench for serial_add_ctrl (WIDTH 8 and 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;
    logic       fa_a2, fa_b2, fa_cin2, fa_sum2, fa_cout2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural full-adder cells
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
    assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_cout2 = (fa_a2 & fa_b2) | (fa_cin2 & (fa_a2 ^ fa_b2));

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADD_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2),
        .fa_sum(fa_sum2), .fa_cout(fa_cout2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle after the accepting edge; returns in the done cycle.
    task automatic body(input logic [7:0] a_v, input logic [7:0] b_eff, input logic c_eff,
                        input logic [7:0] es, input logic ec, input bit inject);
        logic c;
        c = c_eff;
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("fa_a", fa_a, a_v[i]);
            chk("fa_b", fa_b, b_eff[i]);
            chk("fa_cin", fa_cin, c);
            c = (a_v[i] & b_eff[i]) | (c & (a_v[i] ^ b_eff[i]));
            if (inject && i == 2) begin
                start = 1'b1; a = 8'h10; b = 8'h10;
            end
            tick();
            if (inject && i == 2) start = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("sum", sum, es);
        chk("cout", cout, ec);
    endtask

    task automatic op(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                      input logic s_v, input logic [7:0] es, input logic ec);
        start = 1'b1; a = a_v; b = b_v; cin = c_v; sub = s_v;
        tick();
        start = 1'b0;
        body(a_v, s_v ? ~b_v : b_v, s_v ? 1'b1 : c_v, es, ec, 1'b0);
        tick();
        chk("done_after", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        chk("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        tick();

        // Basic add and carry chains
        op(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Start ignored mid-RUN, then back-to-back start in the done cycle
        start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0;
        tick();
        start = 1'b0;
        body(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b1);
        start = 1'b1; a = 8'h20; b = 8'h22; cin = 1'b1;
        tick();
        start = 1'b0;
        body(8'h20, 8'h22, 1'b1, 8'h43, 1'b0, 1'b0);
        tick();
        chk("b2b_done_after", done, 0);

        // Reset in bit-cycle 4
        start = 1'b1; a = 8'h55; b = 8'h0F; cin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_fa", {fa_a, fa_b, fa_cin}, 0);
        for (int i = 0; i < 10; i++) begin
            chk("no_done_after_rst", done, 0);
            tick();
        end
        op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // Exhaustive WIDTH=2
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    logic [2:0] tot;
                    tot = 3'(av) + 3'(bv) + 3'(cv);
                    start2 = 1'b1; a2 = 2'(av); b2 = 2'(bv); cin2 = 1'(cv);
                    tick();
                    start2 = 1'b0;
                    chk("w2_busy1", busy2, 1);
                    chk("w2_done1", done2, 0);
                    tick();
                    chk("w2_busy2", busy2, 1);
                    chk("w2_done2", done2, 0);
                    tick();
                    chk("w2_done", done2, 1);
                    chk("w2_sum", sum2, tot[1:0]);
                    chk("w2_cout", cout2, tot[2]);
                    tick();
                end
            end
        end

`ifdef SERIAL_ADD_SUB_EN
        op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
        op(8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
